// File: rtl/scope_capture_seq_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package     : scope_pkg                                          |
// | Description : State encoding and trigger-edge constants shared   |
// |               by the scope capture write-side sequencer.         |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package scope_pkg;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WAIT_EMPTY = 3'd1;
  localparam logic [2:0] S_WAIT_TRIG  = 3'd2;
  localparam logic [2:0] S_CAPTURE    = 3'd3;
  localparam logic [2:0] S_DONE       = 3'd4;

  localparam logic TRIG_RISE = 1'b0;
  localparam logic TRIG_FALL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE       = S_IDLE,
    ST_WAIT_EMPTY = S_WAIT_EMPTY,
    ST_WAIT_TRIG  = S_WAIT_TRIG,
    ST_CAPTURE    = S_CAPTURE,
    ST_DONE       = S_DONE
  } state_t;

endpackage
`default_nettype wire

// File: rtl/scope_capture_seq_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Interface   : scope_capture_seq_if                               |
// | Description : ADC input, control, FIFO write and status signals  |
// |               of the scope capture sequencer.                    |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
interface scope_capture_seq_if #(
  parameter int DATA_W = 8,
  parameter int LVL_W  = 10,
  parameter int CNT_W  = 16
);
  logic [DATA_W-1:0] adc_data;
  logic              adc_valid;
  logic              arm;
  logic              abort;
  logic [DATA_W-1:0] trig_level;
  logic              trig_falling;
  logic              force_trig;
  logic [CNT_W-1:0]  decim;
  logic [CNT_W-1:0]  cap_len;
  logic              fifo_wfull;
  logic [LVL_W-1:0]  fifo_wr_level;
  logic              fifo_w_en;
  logic [DATA_W-1:0] fifo_wdata;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [2:0]        state_o;

  // Control/ADC/FIFO-status side
  modport master (
    output adc_data, adc_valid, arm, abort, trig_level, trig_falling,
           force_trig, decim, cap_len, fifo_wfull, fifo_wr_level,
    input  fifo_w_en, fifo_wdata, busy, done, overflow, state_o
  );

  // Sequencer side
  modport slave (
    input  adc_data, adc_valid, arm, abort, trig_level, trig_falling,
           force_trig, decim, cap_len, fifo_wfull, fifo_wr_level,
    output fifo_w_en, fifo_wdata, busy, done, overflow, state_o
  );
endinterface
`default_nettype wire

// File: rtl/scope_capture_seq_trig_detect.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : scope_trig_detect                                  |
// | Description : Sample decimation and level/edge trigger compare.  |
// |               o_accept marks a kept sample, o_hit a trigger.     |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module scope_trig_detect
  import scope_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  wire logic              wclk,
  input  wire logic              wrst,
  input  wire logic              i_active,
  input  wire logic              i_wait_trig,
  input  wire logic              i_clr,
  input  wire logic              i_adc_valid,
  input  wire logic [DATA_W-1:0] i_adc_data,
  input  wire logic [CNT_W-1:0]  i_decim,
  input  wire logic [DATA_W-1:0] i_lvl,
  input  wire logic              i_falling,
  output logic                   o_accept,
  output logic                   o_hit
);

  logic [CNT_W-1:0]  r_dcnt;
  logic [DATA_W-1:0] r_prev;
  logic              r_have_prev;
  logic              w_rise;
  logic              w_fall;

  assign o_accept = i_active & i_adc_valid & (r_dcnt == '0);
  assign w_rise   = (r_prev <  i_lvl) && (i_adc_data >= i_lvl);
  assign w_fall   = (r_prev >= i_lvl) && (i_adc_data <  i_lvl);
  // The first kept sample after entering WAIT_TRIG only seeds prev
  assign o_hit    = o_accept & i_wait_trig & r_have_prev &
                    ((i_falling == TRIG_FALL) ? w_fall : w_rise);

  // Decimation counter: keep a sample at zero, then reload with decim
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_dcnt <= '0;
    end else if (i_clr) begin
      r_dcnt <= '0;
    end else if (i_active && i_adc_valid) begin
      if (r_dcnt == '0) r_dcnt <= i_decim;
      else              r_dcnt <= r_dcnt - 1'b1;
    end
  end

  // Previous kept sample and its validity within the current WAIT_TRIG
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_prev      <= '0;
      r_have_prev <= 1'b0;
    end else begin
      if (!i_wait_trig)  r_have_prev <= 1'b0;
      else if (o_accept) r_have_prev <= 1'b1;
      if (o_accept)      r_prev      <= i_adc_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/scope_capture_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : scope_capture_seq                                  |
// | Description : Write-side sample FIFO sequencer: waits for empty  |
// |               FIFO, triggers, writes cap_len decimated samples.  |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module scope_capture_seq
  import scope_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LVL_W  = 10,
  parameter int CNT_W  = 16
) (
  input  wire logic          wclk,
  input  wire logic          wrst,
  scope_capture_seq_if.slave io_bus
);

  state_t            r_state;
  logic [CNT_W-1:0]  r_decim;
  logic [CNT_W-1:0]  r_cap_len;
  logic [DATA_W-1:0] r_lvl;
  logic              r_falling;
  logic [CNT_W-1:0]  r_remain;
  logic              r_force_pend;
  logic              r_w_en;
  logic [DATA_W-1:0] r_wdata;
  logic              r_overflow;

  logic w_active;
  logic w_wait_trig;
  logic w_arm_go;
  logic w_accept;
  logic w_hit;
  logic w_trig;

  assign w_wait_trig = (r_state == ST_WAIT_TRIG);
  assign w_active    = w_wait_trig || (r_state == ST_CAPTURE);
  assign w_arm_go    = io_bus.arm && !io_bus.abort &&
                       ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_trig      = w_accept && (w_hit || r_force_pend || io_bus.force_trig);

  scope_trig_detect #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_trig (
    .wclk        (wclk),
    .wrst        (wrst),
    .i_active    (w_active),
    .i_wait_trig (w_wait_trig),
    .i_clr       (w_arm_go),
    .i_adc_valid (io_bus.adc_valid),
    .i_adc_data  (io_bus.adc_data),
    .i_decim     (r_decim),
    .i_lvl       (r_lvl),
    .i_falling   (r_falling),
    .o_accept    (w_accept),
    .o_hit       (w_hit)
  );

  // Capture FSM with length counter and registered FIFO write port
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_state      <= ST_IDLE;
      r_decim      <= '0;
      r_cap_len    <= '0;
      r_lvl        <= '0;
      r_falling    <= 1'b0;
      r_remain     <= '0;
      r_force_pend <= 1'b0;
      r_w_en       <= 1'b0;
      r_wdata      <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_w_en <= 1'b0;
      if (io_bus.abort) begin
        r_state      <= ST_IDLE;
        r_force_pend <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE, ST_DONE: begin
            if (io_bus.arm) begin
              r_decim    <= io_bus.decim;
              r_cap_len  <= (io_bus.cap_len == '0) ? CNT_W'(1) : io_bus.cap_len;
              r_lvl      <= io_bus.trig_level;
              r_falling  <= io_bus.trig_falling;
              r_overflow <= 1'b0;
              r_state    <= ST_WAIT_EMPTY;
            end
          end
          ST_WAIT_EMPTY: begin
            r_force_pend <= 1'b0;
            if (io_bus.fifo_wr_level == '0) r_state <= ST_WAIT_TRIG;
          end
          ST_WAIT_TRIG: begin
            if (io_bus.force_trig) r_force_pend <= 1'b1;
            if (w_trig) begin
              r_force_pend <= 1'b0;
              if (io_bus.fifo_wfull) begin
                r_overflow <= 1'b1;
                r_state    <= ST_DONE;
              end else begin
                r_w_en   <= 1'b1;
                r_wdata  <= io_bus.adc_data;
                r_remain <= r_cap_len - 1'b1;
                r_state  <= (r_cap_len == CNT_W'(1)) ? ST_DONE : ST_CAPTURE;
              end
            end
          end
          ST_CAPTURE: begin
            if (w_accept) begin
              if (io_bus.fifo_wfull) begin
                r_overflow <= 1'b1;
                r_state    <= ST_DONE;
              end else begin
                r_w_en   <= 1'b1;
                r_wdata  <= io_bus.adc_data;
                r_remain <= r_remain - 1'b1;
                if (r_remain == CNT_W'(1)) r_state <= ST_DONE;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign io_bus.fifo_w_en  = r_w_en;
  assign io_bus.fifo_wdata = r_wdata;
  assign io_bus.overflow   = r_overflow;
  assign io_bus.state_o    = r_state;
  assign io_bus.busy       = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign io_bus.done       = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_scope_capture_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_scope_capture_seq                               |
// | Description : Directed self-checking bench for scope_capture_seq |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module tb_scope_capture_seq;

  logic wclk = 1'b0;
  logic wrst = 1'b1;
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 wclk = ~wclk;

  scope_capture_seq_if #(.DATA_W(8), .LVL_W(10), .CNT_W(16)) bus ();

  scope_capture_seq #(.DATA_W(8), .LVL_W(10), .CNT_W(16)) dut (
    .wclk   (wclk),
    .wrst   (wrst),
    .io_bus (bus)
  );

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sample(input logic [7:0] d);
    bus.adc_data  = d;
    bus.adc_valid = 1'b1;
    tick();
    bus.adc_valid = 1'b0;
  endtask

  task automatic pulse_arm();
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".w_en"},  32'(bus.fifo_w_en), 32'd0);
    check({tag, ".wdata"}, 32'(bus.fifo_wdata), 32'd0);
    check({tag, ".busy"},  32'(bus.busy), 32'd0);
    check({tag, ".done"},  32'(bus.done), 32'd0);
    check({tag, ".ovf"},   32'(bus.overflow), 32'd0);
    check({tag, ".state"}, 32'(bus.state_o), 32'd0);
  endtask

  initial begin
    bus.adc_data = '0; bus.adc_valid = 0; bus.arm = 0; bus.abort = 0;
    bus.trig_level = '0; bus.trig_falling = 0; bus.force_trig = 0;
    bus.decim = '0; bus.cap_len = '0; bus.fifo_wfull = 0; bus.fifo_wr_level = '0;
    tick(); tick();
    check_all_zero("reset");
    wrst = 1'b0;
    tick();

    // 1: rising trigger at 0x80, cap_len 4
    bus.decim = 16'd0; bus.cap_len = 16'd4; bus.trig_level = 8'h80; bus.trig_falling = 0;
    pulse_arm();
    check("t1.wait_empty", 32'(bus.state_o), 32'd1);
    check("t1.busy", 32'(bus.busy), 32'd1);
    tick();
    check("t1.wait_trig", 32'(bus.state_o), 32'd2);
    sample(8'h7E); check("t1.w_en_7E", 32'(bus.fifo_w_en), 32'd0);
    sample(8'h7F); check("t1.w_en_7F", 32'(bus.fifo_w_en), 32'd0);
    for (int i = 0; i < 4; i++) begin
      sample(8'(8'h80 + i));
      check("t1.w_en", 32'(bus.fifo_w_en), 32'd1);
      check("t1.wdata", 32'(bus.fifo_wdata), 32'(8'h80 + i));
    end
    check("t1.done", 32'(bus.done), 32'd1);
    check("t1.busy_off", 32'(bus.busy), 32'd0);
    check("t1.state", 32'(bus.state_o), 32'd4);
    sample(8'h84);
    check("t1.no_extra", 32'(bus.fifo_w_en), 32'd0);

    // 2: non-empty FIFO holds WAIT_EMPTY
    bus.fifo_wr_level = 10'd5;
    pulse_arm();
    for (int i = 0; i < 3; i++) begin
      sample(8'h90);
      check("t2.hold", 32'(bus.state_o), 32'd1);
      check("t2.no_wr", 32'(bus.fifo_w_en), 32'd0);
    end
    bus.fifo_wr_level = 10'd0;
    tick();
    check("t2.to_trig", 32'(bus.state_o), 32'd2);
    bus.abort = 1'b1; tick(); bus.abort = 1'b0;
    check("t2.abort_idle", 32'(bus.state_o), 32'd0);

    // 3: decim=2, cap_len=3, forced trigger
    bus.decim = 16'd2; bus.cap_len = 16'd3;
    pulse_arm(); tick();
    check("t3.wait_trig", 32'(bus.state_o), 32'd2);
    bus.force_trig = 1'b1; tick(); bus.force_trig = 1'b0;
    for (int s = 0; s < 12; s++) begin
      sample(8'(s));
      check("t3.w_en", 32'(bus.fifo_w_en), (s == 0 || s == 3 || s == 6) ? 32'd1 : 32'd0);
      if (s == 0 || s == 3 || s == 6) check("t3.wdata", 32'(bus.fifo_wdata), 32'(s));
    end
    check("t3.done", 32'(bus.done), 32'd1);

    // 4: FIFO full on 2nd capture sample
    bus.decim = 16'd0; bus.cap_len = 16'd8; bus.trig_level = 8'h80;
    pulse_arm(); tick();
    sample(8'h10);
    check("t4.prev_only", 32'(bus.fifo_w_en), 32'd0);
    sample(8'h90);
    check("t4.w_en1", 32'(bus.fifo_w_en), 32'd1);
    check("t4.wdata1", 32'(bus.fifo_wdata), 32'h90);
    check("t4.capture", 32'(bus.state_o), 32'd3);
    bus.fifo_wfull = 1'b1;
    sample(8'hA0);
    bus.fifo_wfull = 1'b0;
    check("t4.no_wr", 32'(bus.fifo_w_en), 32'd0);
    check("t4.ovf", 32'(bus.overflow), 32'd1);
    check("t4.done", 32'(bus.state_o), 32'd4);
    bus.trig_falling = 1'b1; bus.trig_level = 8'h40; bus.cap_len = 16'd0;
    pulse_arm();
    check("t4.ovf_clr", 32'(bus.overflow), 32'd0);

    // 5: falling edge at 0x40, cap_len 0 acts as 1
    tick();
    sample(8'h50); check("t5.w_en_50", 32'(bus.fifo_w_en), 32'd0);
    sample(8'h40); check("t5.w_en_40", 32'(bus.fifo_w_en), 32'd0);
    check("t5.still_trig", 32'(bus.state_o), 32'd2);
    sample(8'h3F);
    check("t5.w_en_3F", 32'(bus.fifo_w_en), 32'd1);
    check("t5.wdata", 32'(bus.fifo_wdata), 32'h3F);
    check("t5.done", 32'(bus.state_o), 32'd4);

    // 6a: abort mid-capture
    bus.trig_falling = 1'b0; bus.trig_level = 8'h80; bus.cap_len = 16'd8;
    pulse_arm(); tick();
    sample(8'h00); sample(8'h80);
    check("t6.w_en_80", 32'(bus.fifo_w_en), 32'd1);
    sample(8'h81);
    check("t6.w_en_81", 32'(bus.fifo_w_en), 32'd1);
    bus.abort = 1'b1; bus.arm = 1'b1;
    sample(8'h82);
    bus.abort = 1'b0; bus.arm = 1'b0;
    check("t6.abort_idle", 32'(bus.state_o), 32'd0);
    check("t6.abort_no_wr", 32'(bus.fifo_w_en), 32'd0);
    sample(8'h83);
    check("t6.abort_quiet", 32'(bus.fifo_w_en), 32'd0);

    // 6b: asynchronous reset mid-capture
    pulse_arm(); tick();
    sample(8'h00); sample(8'h85);
    check("t6.w_en_85", 32'(bus.fifo_w_en), 32'd1);
    bus.adc_data = 8'h86; bus.adc_valid = 1'b1;
    #2 wrst = 1'b1;
    #1 check_all_zero("t6.rst");
    tick(); tick();
    wrst = 1'b0;
    sample(8'h87);
    check("t6.post_rst_state", 32'(bus.state_o), 32'd0);
    check("t6.post_rst_wen", 32'(bus.fifo_w_en), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
